// File: rtl/vga_dev_pkg.sv
// rtl/vga_dev_pkg.sv - shared bus control pins, VGA timing defaults and bus FSM states
package vga_dev_pkg;

  // Control-pin encoding shared with the mobo and the RAM device
  localparam int CTRL_READ  = 1;
  localparam int CTRL_WRITE = 2;
  localparam int STAT_IDLE  = 0;
  localparam int STAT_DONE  = 1;

  // 640x480 timing defaults and framebuffer downscale
  localparam int DEF_H_ACTIVE = 640;
  localparam int DEF_H_FP     = 16;
  localparam int DEF_H_SYNC   = 96;
  localparam int DEF_H_BP     = 48;
  localparam int DEF_V_ACTIVE = 480;
  localparam int DEF_V_FP     = 10;
  localparam int DEF_V_SYNC   = 2;
  localparam int DEF_V_BP     = 33;
  localparam int DEF_FB_SHIFT = 3;

  localparam int CNT_W = 12;

  typedef enum logic [1:0] {
    D_IDLE,
    D_ACCESS,
    D_DONE
  } dev_state_t;

  function automatic int fb_dim(input int active, input int shift);
    return active >> shift;
  endfunction

endpackage

// File: rtl/vga_dev_timing.sv
// rtl/vga_dev_timing.sv - horizontal/vertical scan counters, frame counter and raw sync/active flags
import vga_dev_pkg::*;

module vga_timing #(
  parameter int WORD_WIDTH = 16,
  parameter int H_ACTIVE   = DEF_H_ACTIVE,
  parameter int H_FP       = DEF_H_FP,
  parameter int H_SYNC     = DEF_H_SYNC,
  parameter int H_BP       = DEF_H_BP,
  parameter int V_ACTIVE   = DEF_V_ACTIVE,
  parameter int V_FP       = DEF_V_FP,
  parameter int V_SYNC     = DEF_V_SYNC,
  parameter int V_BP       = DEF_V_BP
) (
  input  logic                  clk,
  input  logic                  rst,
  output logic [CNT_W-1:0]      h_cnt,
  output logic [CNT_W-1:0]      v_cnt,
  output logic [WORD_WIDTH-1:0] frame_cnt,
  output logic                  hsync_raw,
  output logic                  vsync_raw,
  output logic                  active
);

  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

  logic h_end;
  logic v_end;

  assign h_end = (h_cnt == CNT_W'(H_TOTAL - 1));
  assign v_end = (v_cnt == CNT_W'(V_TOTAL - 1));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      h_cnt     <= '0;
      v_cnt     <= '0;
      frame_cnt <= '0;
    end else begin
      h_cnt <= h_end ? '0 : h_cnt + CNT_W'(1);
      if (h_end) begin
        v_cnt <= v_end ? '0 : v_cnt + CNT_W'(1);
        if (v_end) begin
          frame_cnt <= frame_cnt + WORD_WIDTH'(1);
        end
      end
    end
  end

  // Sync pulses sit between front and back porch and are active-low
  assign hsync_raw = !((h_cnt >= CNT_W'(H_ACTIVE + H_FP)) &&
                       (h_cnt <  CNT_W'(H_ACTIVE + H_FP + H_SYNC)));
  assign vsync_raw = !((v_cnt >= CNT_W'(V_ACTIVE + V_FP)) &&
                       (v_cnt <  CNT_W'(V_ACTIVE + V_FP + V_SYNC)));
  assign active    = (h_cnt < CNT_W'(H_ACTIVE)) && (v_cnt < CNT_W'(V_ACTIVE));

endmodule

// File: rtl/vga_dev.sv
// rtl/vga_dev.sv - VGA device: mobo bus FSM, dual-port framebuffer and 2-stage scan-out pipeline
import vga_dev_pkg::*;

module vga_dev #(
  parameter int WORD_WIDTH = 16,
  parameter int FB_SHIFT   = DEF_FB_SHIFT,
  parameter int H_ACTIVE   = DEF_H_ACTIVE,
  parameter int H_FP       = DEF_H_FP,
  parameter int H_SYNC     = DEF_H_SYNC,
  parameter int H_BP       = DEF_H_BP,
  parameter int V_ACTIVE   = DEF_V_ACTIVE,
  parameter int V_FP       = DEF_V_FP,
  parameter int V_SYNC     = DEF_V_SYNC,
  parameter int V_BP       = DEF_V_BP
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [WORD_WIDTH-1:0] vga_ctrl,
  output logic [WORD_WIDTH-1:0] vga_stat,
  input  logic [WORD_WIDTH-1:0] addr,
  input  logic [WORD_WIDTH-1:0] data_in,
  output logic [WORD_WIDTH-1:0] data_out,
  output logic                  hsync,
  output logic                  vsync,
  output logic                  de,
  output logic [7:0]            rgb
);

  localparam int FB_W    = fb_dim(H_ACTIVE, FB_SHIFT);
  localparam int FB_H    = fb_dim(V_ACTIVE, FB_SHIFT);
  localparam int FB_SIZE = FB_W * FB_H;
  localparam int FB_AW   = $clog2(FB_SIZE);

  logic [CNT_W-1:0]      h_cnt;
  logic [CNT_W-1:0]      v_cnt;
  logic [WORD_WIDTH-1:0] frame_cnt;
  logic                  hsync_raw;
  logic                  vsync_raw;
  logic                  active;

  vga_timing #(
    .WORD_WIDTH (WORD_WIDTH),
    .H_ACTIVE   (H_ACTIVE),
    .H_FP       (H_FP),
    .H_SYNC     (H_SYNC),
    .H_BP       (H_BP),
    .V_ACTIVE   (V_ACTIVE),
    .V_FP       (V_FP),
    .V_SYNC     (V_SYNC),
    .V_BP       (V_BP)
  ) u_timing (
    .clk       (clk),
    .rst       (rst),
    .h_cnt     (h_cnt),
    .v_cnt     (v_cnt),
    .frame_cnt (frame_cnt),
    .hsync_raw (hsync_raw),
    .vsync_raw (vsync_raw),
    .active    (active)
  );

  dev_state_t            state;
  dev_state_t            state_nxt;
  logic [WORD_WIDTH-1:0] data_q;
  logic [WORD_WIDTH-1:0] rd_value;
  logic                  do_read;
  logic                  do_write;
  logic                  in_range;
  logic                  fb_we;
  logic [FB_AW-1:0]      bus_idx;
  logic [FB_AW-1:0]      scan_idx;
  logic [7:0]            scan_px;
  logic [7:0]            fb_mem [FB_SIZE];
  logic                  hs_d1;
  logic                  vs_d1;
  logic                  de_d1;
  logic                  unused_data_hi;

  assign unused_data_hi = ^data_in[WORD_WIDTH-1:8];

  // Read has priority when the mobo raises both request bits
  assign do_read  = (vga_ctrl & WORD_WIDTH'(CTRL_READ)) != '0;
  assign do_write = ((vga_ctrl & WORD_WIDTH'(CTRL_WRITE)) != '0) && !do_read;
  assign in_range = addr < WORD_WIDTH'(FB_SIZE);
  assign bus_idx  = addr[FB_AW-1:0];
  assign fb_we    = (state == D_ACCESS) && do_write && in_range;

  always_comb begin
    rd_value = '0;
    if (in_range) begin
      rd_value = WORD_WIDTH'(fb_mem[bus_idx]);
    end else if (addr == WORD_WIDTH'(FB_SIZE)) begin
      rd_value = frame_cnt;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state  <= D_IDLE;
      data_q <= '0;
    end else begin
      state <= state_nxt;
      if (state == D_ACCESS) begin
        data_q <= do_read ? rd_value : '0;
      end
    end
  end

  always_comb begin
    state_nxt = state;
    vga_stat  = WORD_WIDTH'(STAT_IDLE);
    data_out  = '0;
    case (state)
      D_IDLE: begin
        if (vga_ctrl != '0) begin
          state_nxt = D_ACCESS;
        end
      end
      D_ACCESS: begin
        state_nxt = D_DONE;
      end
      D_DONE: begin
        vga_stat = WORD_WIDTH'(STAT_DONE);
        data_out = data_q;
        if (vga_ctrl == '0) begin
          state_nxt = D_IDLE;
        end
      end
      default: begin
        state_nxt = D_IDLE;
      end
    endcase
  end

  // Blanking addresses fall outside the buffer, so park the scan port on word 0
  assign scan_idx = active ?
    FB_AW'(((32'(v_cnt) >> FB_SHIFT) * FB_W) + (32'(h_cnt) >> FB_SHIFT)) : '0;

  // Non-blocking scan read returns the pre-write word on a same-cycle collision
  always_ff @(posedge clk) begin
    if (fb_we) begin
      fb_mem[bus_idx] <= data_in[7:0];
    end
    scan_px <= fb_mem[scan_idx];
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      hs_d1 <= 1'b1;
      vs_d1 <= 1'b1;
      de_d1 <= 1'b0;
      hsync <= 1'b1;
      vsync <= 1'b1;
      de    <= 1'b0;
      rgb   <= 8'h00;
    end else begin
      hs_d1 <= hsync_raw;
      vs_d1 <= vsync_raw;
      de_d1 <= active;
      hsync <= hs_d1;
      vsync <= vs_d1;
      de    <= de_d1;
      rgb   <= de_d1 ? scan_px : 8'h00;
    end
  end

endmodule
